// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side uses the
// master modport; hazard_ctrl sits on the slave modport.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_mem_read_i;
    logic             branch_taken_i;
    logic             mem_busy_i;
    logic             pc_write_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             pipe_freeze_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [1:0]       state_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_rd_i, ex_mem_read_i,
               branch_taken_i, mem_busy_i,
        input  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o,
               pipe_freeze_o, mem_timeout_o, stall_cnt_o, state_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_rd_i, ex_mem_read_i,
               branch_taken_i, mem_busy_i,
        output pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o,
               pipe_freeze_o, mem_timeout_o, stall_cnt_o, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage CPU: boot flush, load-use
// bubbles, taken-branch flush and whole-pipe freeze while data memory is busy.
module hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES  = 3,
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned WW = (MAX_MEM_WAIT > 0) ? $clog2(MAX_MEM_WAIT + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_MEM_WAIT);

    logic [1:0]       state_q;
    logic [1:0]       next_state;
    logic [BW-1:0]    boot_cnt_q;
    logic [WW-1:0]    wait_cnt_q;
    logic [WW-1:0]    wait_inc;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hazard;
    logic             pc_write;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             freeze;
    logic             running;

    assign hazard = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
                    ((hz.ex_rd_i == hz.id_rs1_i) ||
                     (hz.id_uses_rs2_i && (hz.ex_rd_i == hz.id_rs2_i)));

    assign running  = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign wait_inc = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    always_comb begin
        pc_write    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        freeze      = 1'b0;
        next_state  = state_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                // RUN and MEM_WAIT share one decode: busy freezes, otherwise normal RUN priority
                if (hz.mem_busy_i) begin
                    if_id_stall = 1'b1;
                    freeze      = 1'b1;
                    next_state  = ST_MEM_WAIT;
                end else begin
                    next_state = ST_RUN;
                    if (hazard) begin
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (hz.branch_taken_i) begin
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end
            end
            default: begin
                // BOOT, and recovery path for the unused encoding
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (state_q != ST_BOOT || boot_cnt_q == BOOT_LAST) begin
                    next_state = (state_q == ST_BOOT) ? ST_RUN : ST_BOOT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= next_state;
            if ((state_q == ST_BOOT) && (next_state == ST_BOOT)) begin
                boot_cnt_q <= boot_cnt_q + 1'b1;
            end else begin
                boot_cnt_q <= '0;
            end
            // Every frozen cycle counts as a wait cycle, including the RUN cycle that enters the wait
            if (freeze) begin
                wait_cnt_q <= wait_inc;
                if (wait_inc == WAIT_MAX) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
            if (running && !pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.if_id_stall_o = if_id_stall;
    assign hz.if_id_flush_o = if_id_flush;
    assign hz.id_ex_flush_o = id_ex_flush;
    assign hz.pipe_freeze_o = freeze;
    assign hz.mem_timeout_o = timeout_q;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.state_o       = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: boot, load-use, branch priority, memory waits,
// timeout, counter saturation (narrow-counter instance) and async reset mid-wait.
module tb_hazard_ctrl;
    logic clk_i = 1'b0;
    logic rst_n_i;
    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned exp_stall = 0;

    // {pc_write, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [4:0] CTL_BOOT = 5'b00110;
    localparam logic [4:0] CTL_RUN  = 5'b10000;
    localparam logic [4:0] CTL_HAZ  = 5'b01010;
    localparam logic [4:0] CTL_BR   = 5'b10100;
    localparam logic [4:0] CTL_WAIT = 5'b01001;

    hazard_ctrl_if #(.CNT_W(16)) hz ();
    hazard_ctrl_if #(.CNT_W(2))  hz2 ();

    hazard_ctrl #(.BOOT_CYCLES(3), .MAX_MEM_WAIT(15), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .hz(hz)
    );
    hazard_ctrl #(.BOOT_CYCLES(3), .MAX_MEM_WAIT(15), .CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .hz(hz2)
    );

    assign hz2.id_rs1_i       = hz.id_rs1_i;
    assign hz2.id_rs2_i       = hz.id_rs2_i;
    assign hz2.id_uses_rs2_i  = hz.id_uses_rs2_i;
    assign hz2.ex_rd_i        = hz.ex_rd_i;
    assign hz2.ex_mem_read_i  = hz.ex_mem_read_i;
    assign hz2.branch_taken_i = hz.branch_taken_i;
    assign hz2.mem_busy_i     = hz.mem_busy_i;

    logic [4:0] ctl;
    assign ctl = {hz.pc_write_o, hz.if_id_stall_o, hz.if_id_flush_o, hz.id_ex_flush_o, hz.pipe_freeze_o};

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic       haz;
    } vec_t;

    vec_t lu_vecs [6] = '{
        '{1'b1, 5'd5,  5'd3, 5'd5,  1'b1, 1'b1},
        '{1'b1, 5'd0,  5'd0, 5'd5,  1'b1, 1'b0},
        '{1'b1, 5'd7,  5'd7, 5'd1,  1'b0, 1'b1},
        '{1'b1, 5'd7,  5'd2, 5'd7,  1'b0, 1'b0},
        '{1'b0, 5'd7,  5'd7, 5'd7,  1'b1, 1'b0},
        '{1'b1, 5'd31, 5'd4, 5'd31, 1'b1, 1'b1}
    };

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        hz.id_rs1_i       = 5'd0;
        hz.id_rs2_i       = 5'd0;
        hz.id_uses_rs2_i  = 1'b0;
        hz.ex_rd_i        = 5'd0;
        hz.ex_mem_read_i  = 1'b0;
        hz.branch_taken_i = 1'b0;
        hz.mem_busy_i     = 1'b0;
    endtask

    task automatic set_hazard();
        hz.ex_mem_read_i = 1'b1;
        hz.ex_rd_i       = 5'd5;
        hz.id_rs1_i      = 5'd5;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n_i = 1'b0;
        #2;
        total++; if (ctl !== CTL_BOOT) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_BOOT); else passed++;
        total++; if (hz.state_o !== 2'd0) $display("FAIL reset_state: got %0d expected 0", hz.state_o); else passed++;
        total++; if (hz.stall_cnt_o !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", hz.stall_cnt_o); else passed++;
        total++; if (hz.mem_timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", hz.mem_timeout_o); else passed++;
        tick();
        tick();
        rst_n_i = 1'b1;
        // Inputs that would stall in RUN must be ignored during BOOT
        hz.mem_busy_i = 1'b1;
        set_hazard();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (hz.state_o !== 2'd0) $display("FAIL boot_state[%0d]: got %0d expected 0", i, hz.state_o); else passed++;
            total++; if (ctl !== CTL_BOOT) $display("FAIL boot_ctl[%0d]: got %b expected %b", i, ctl, CTL_BOOT); else passed++;
            tick();
        end
        set_idle();
        #1;
        total++; if (hz.state_o !== 2'd1) $display("FAIL boot_exit_state: got %0d expected 1", hz.state_o); else passed++;
        total++; if (ctl !== CTL_RUN) $display("FAIL boot_exit_ctl: got %b expected %b", ctl, CTL_RUN); else passed++;
        total++; if (hz.stall_cnt_o !== 16'd0) $display("FAIL boot_stall_cnt: got %0d expected 0", hz.stall_cnt_o); else passed++;
    endtask

    task automatic test_load_use();
        logic [4:0] exp_ctl;
        for (int i = 0; i < 6; i++) begin
            hz.ex_mem_read_i = lu_vecs[i].mr;
            hz.ex_rd_i       = lu_vecs[i].rd;
            hz.id_rs1_i      = lu_vecs[i].rs1;
            hz.id_rs2_i      = lu_vecs[i].rs2;
            hz.id_uses_rs2_i = lu_vecs[i].u2;
            #1;
            exp_ctl = lu_vecs[i].haz ? CTL_HAZ : CTL_RUN;
            total++; if (ctl !== exp_ctl) $display("FAIL load_use_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl); else passed++;
            total++; if (hz.stall_cnt_o !== 16'(exp_stall)) $display("FAIL load_use_cnt[%0d]: got %0d expected %0d", i, hz.stall_cnt_o, exp_stall); else passed++;
            if (lu_vecs[i].haz) exp_stall++;
            tick();
        end
        set_idle();
        #1;
        total++; if (hz.stall_cnt_o !== 16'(exp_stall)) $display("FAIL load_use_cnt_end: got %0d expected %0d", hz.stall_cnt_o, exp_stall); else passed++;
        total++; if (hz.state_o !== 2'd1) $display("FAIL load_use_state: got %0d expected 1", hz.state_o); else passed++;
    endtask

    task automatic test_branch_vs_hazard();
        set_hazard();
        hz.branch_taken_i = 1'b1;
        #1;
        total++; if (ctl !== CTL_HAZ) $display("FAIL br_haz_ctl: got %b expected %b", ctl, CTL_HAZ); else passed++;
        exp_stall++;
        tick();
        hz.ex_mem_read_i = 1'b0;
        #1;
        total++; if (ctl !== CTL_BR) $display("FAIL br_retry_ctl: got %b expected %b", ctl, CTL_BR); else passed++;
        tick();
        set_idle();
        #1;
        total++; if (ctl !== CTL_RUN) $display("FAIL br_after_ctl: got %b expected %b", ctl, CTL_RUN); else passed++;
        total++; if (hz.stall_cnt_o !== 16'(exp_stall)) $display("FAIL br_cnt: got %0d expected %0d", hz.stall_cnt_o, exp_stall); else passed++;
    endtask

    task automatic test_mem_wait_short();
        logic [1:0] exp_state;
        hz.mem_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                set_hazard();
                hz.branch_taken_i = 1'b1;
            end
            #1;
            exp_state = (i == 0) ? 2'd1 : 2'd2;
            total++; if (ctl !== CTL_WAIT) $display("FAIL wait_ctl[%0d]: got %b expected %b", i, ctl, CTL_WAIT); else passed++;
            total++; if (hz.state_o !== exp_state) $display("FAIL wait_state[%0d]: got %0d expected %0d", i, hz.state_o, exp_state); else passed++;
            exp_stall++;
            tick();
        end
        // Exit cycle decodes as RUN: the pending load-use hazard applies
        hz.mem_busy_i = 1'b0;
        #1;
        total++; if (hz.state_o !== 2'd2) $display("FAIL wait_exit_state: got %0d expected 2", hz.state_o); else passed++;
        total++; if (ctl !== CTL_HAZ) $display("FAIL wait_exit_ctl: got %b expected %b", ctl, CTL_HAZ); else passed++;
        total++; if (hz.stall_cnt_o !== 16'(exp_stall)) $display("FAIL wait_cnt: got %0d expected %0d", hz.stall_cnt_o, exp_stall); else passed++;
        total++; if (hz.mem_timeout_o !== 1'b0) $display("FAIL wait_no_timeout: got %b expected 0", hz.mem_timeout_o); else passed++;
        exp_stall++;
        tick();
        set_idle();
        #1;
        total++; if (hz.state_o !== 2'd1) $display("FAIL wait_back_run: got %0d expected 1", hz.state_o); else passed++;
        total++; if (ctl !== CTL_RUN) $display("FAIL wait_back_ctl: got %b expected %b", ctl, CTL_RUN); else passed++;
    endtask

    task automatic test_mem_timeout();
        logic exp_to;
        hz.mem_busy_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_to = (i >= 15);
            total++; if (hz.mem_timeout_o !== exp_to) $display("FAIL timeout[%0d]: got %b expected %b", i, hz.mem_timeout_o, exp_to); else passed++;
            exp_stall++;
            tick();
        end
        hz.mem_busy_i = 1'b0;
        #1;
        total++; if (ctl !== CTL_RUN) $display("FAIL timeout_exit_ctl: got %b expected %b", ctl, CTL_RUN); else passed++;
        tick();
        total++; if (hz.mem_timeout_o !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", hz.mem_timeout_o); else passed++;
        total++; if (hz.state_o !== 2'd1) $display("FAIL timeout_state: got %0d expected 1", hz.state_o); else passed++;
        total++; if (hz.stall_cnt_o !== 16'(exp_stall)) $display("FAIL timeout_cnt: got %0d expected %0d", hz.stall_cnt_o, exp_stall); else passed++;
        total++; if (hz2.stall_cnt_o !== 2'd3) $display("FAIL stall_cnt_saturate: got %0d expected 3", hz2.stall_cnt_o); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        hz.mem_busy_i = 1'b1;
        tick();
        tick();
        total++; if (hz.state_o !== 2'd2) $display("FAIL rst_pre_state: got %0d expected 2", hz.state_o); else passed++;
        #2;
        rst_n_i = 1'b0;
        #1;
        total++; if (ctl !== CTL_BOOT) $display("FAIL rst_mid_ctl: got %b expected %b", ctl, CTL_BOOT); else passed++;
        total++; if (hz.state_o !== 2'd0) $display("FAIL rst_mid_state: got %0d expected 0", hz.state_o); else passed++;
        total++; if (hz.stall_cnt_o !== 16'd0) $display("FAIL rst_mid_cnt: got %0d expected 0", hz.stall_cnt_o); else passed++;
        total++; if (hz.mem_timeout_o !== 1'b0) $display("FAIL rst_mid_timeout: got %b expected 0", hz.mem_timeout_o); else passed++;
        exp_stall = 0;
        tick();
        rst_n_i = 1'b1;
        tick();
        tick();
        #1;
        total++; if (hz.state_o !== 2'd0) $display("FAIL rst_reboot_state: got %0d expected 0", hz.state_o); else passed++;
        tick();
        hz.mem_busy_i = 1'b0;
        #1;
        total++; if (hz.state_o !== 2'd1) $display("FAIL rst_reboot_run: got %0d expected 1", hz.state_o); else passed++;
        total++; if (ctl !== CTL_RUN) $display("FAIL rst_reboot_ctl: got %b expected %b", ctl, CTL_RUN); else passed++;
        total++; if (hz.stall_cnt_o !== 16'd0) $display("FAIL rst_reboot_cnt: got %0d expected 0", hz.stall_cnt_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_hazard();
        test_mem_wait_short();
        test_mem_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
